// File: rtl/wsc_pkg.sv
// Shared types, constants and helpers for the wolf/sheep/cabbage move sequencer.
// State bits are ordered {t,w,s,c}; a bit value of 1 means "on the far bank".
package wsc_pkg;

    typedef enum logic [1:0] {
        MV_NONE  = 2'd0,
        MV_CAB   = 2'd1,
        MV_SHEEP = 2'd2,
        MV_WOLF  = 2'd3
    } move_e;

    typedef enum logic [1:0] {
        RESP_OK       = 2'd0,
        RESP_FAR      = 2'd1,
        RESP_UNSAFE   = 2'd2,
        RESP_MISMATCH = 2'd3
    } resp_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ISSUE  = 3'd2,
        S_VERIFY = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } fsm_e;

    typedef struct packed {
        logic t;
        logic w;
        logic s;
        logic c;
    } state_t;

    localparam logic [3:0] GOAL    = 4'b1111;
    localparam logic [2:0] ROM_LEN = 3'd7;

    // Entry 0 in the least significant pair: sheep, none, wolf, sheep, cab, none, sheep.
    localparam logic [13:0] SOLUTION_ROM = {2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};

    function automatic move_e rom_move(input logic [2:0] idx);
        if (idx < ROM_LEN) begin
            return move_e'(SOLUTION_ROM[{idx, 1'b0} +: 2]);
        end else begin
            return MV_NONE;
        end
    endfunction

    // A bank without the farmer must not hold wolf+sheep or sheep+cabbage.
    function automatic logic is_safe(input state_t st);
        return !(((st.w == st.s) && (st.t != st.s)) ||
                 ((st.s == st.c) && (st.t != st.s)));
    endfunction

endpackage

// File: rtl/wsc_legal_chk.sv
// Combinational legality check of one crossing against the shadow puzzle state.
// Produces the state after the crossing and the response code for the move.
module wsc_legal_chk
    import wsc_pkg::*;
(
    input  state_t shadow,
    input  move_e  move,
    output state_t next,
    output resp_e  code
);

    logic passenger_ok;

    // Toggle farmer and passenger, then grade passenger position before safety.
    always_comb begin
        next         = shadow;
        next.t       = ~shadow.t;
        passenger_ok = 1'b1;
        case (move)
            MV_NONE: begin
                passenger_ok = 1'b1;
            end
            MV_CAB: begin
                passenger_ok = (shadow.c == shadow.t);
                next.c       = ~shadow.c;
            end
            MV_SHEEP: begin
                passenger_ok = (shadow.s == shadow.t);
                next.s       = ~shadow.s;
            end
            MV_WOLF: begin
                passenger_ok = (shadow.w == shadow.t);
                next.w       = ~shadow.w;
            end
            default: begin
                passenger_ok = 1'b0;
            end
        endcase

        if (!passenger_ok) begin
            code = RESP_FAR;
        end else if (!is_safe(next)) begin
            code = RESP_UNSAFE;
        end else begin
            code = RESP_OK;
        end
    end

endmodule

// File: rtl/wsc_sequencer.sv
// Move sequencer and legality gate for the wolf/sheep/cabbage datapath.
// Accepts manual moves or replays the ROM solution; issues only safe moves and cross-checks the datapath.
module wsc_sequencer
    import wsc_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             auto_start,
    input  logic             req_valid,
    input  logic [1:0]       req_move,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [1:0]       resp_code,
    output logic             dp_step,
    output logic             dp_wolf,
    output logic             dp_sheep,
    output logic             dp_cab,
    input  logic [3:0]       dp_state,
    output logic [3:0]       shadow,
    output logic [CNT_W-1:0] moves,
    output logic             done,
    output logic             err
);

    fsm_e             state_r;
    fsm_e             state_nxt;
    logic             ready_r;
    logic             auto_r;
    logic [2:0]       rom_idx_r;
    move_e            move_r;
    state_t           shadow_r;
    logic [CNT_W-1:0] moves_r;
    logic             err_r;

    move_e            cur_move_s;
    state_t           chk_next_s;
    resp_e            chk_code_s;
    resp_e            resp_s;
    logic             accept_s;

    assign cur_move_s = auto_r ? rom_move(rom_idx_r) : move_r;

    wsc_legal_chk u_chk (
        .shadow (shadow_r),
        .move   (cur_move_s),
        .next   (chk_next_s),
        .code   (chk_code_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state and strobe decode; auto_start gates req_ready combinationally so auto wins a tie.
    always_comb begin
        state_nxt  = state_r;
        req_ready  = ready_r & ~auto_r & ~auto_start;
        accept_s   = 1'b0;
        resp_valid = 1'b0;
        resp_s     = RESP_OK;
        dp_step    = 1'b0;
        dp_wolf    = 1'b0;
        dp_sheep   = 1'b0;
        dp_cab     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (auto_start) begin
                    state_nxt = S_CHECK;
                end else if (req_valid && req_ready) begin
                    accept_s  = 1'b1;
                    state_nxt = S_CHECK;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CHECK: begin
                if (chk_code_s == RESP_OK) begin
                    state_nxt = S_ISSUE;
                end else begin
                    resp_valid = 1'b1;
                    resp_s     = chk_code_s;
                    state_nxt  = auto_r ? S_ERR : S_IDLE;
                end
            end
            S_ISSUE: begin
                dp_step   = 1'b1;
                dp_wolf   = (cur_move_s == MV_WOLF);
                dp_sheep  = (cur_move_s == MV_SHEEP);
                dp_cab    = (cur_move_s == MV_CAB);
                state_nxt = S_VERIFY;
            end
            S_VERIFY: begin
                resp_valid = 1'b1;
                if (dp_state == shadow_r) begin
                    resp_s = RESP_OK;
                    if (shadow_r == GOAL) begin
                        state_nxt = S_DONE;
                    end else if (auto_r) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    resp_s    = RESP_MISMATCH;
                    state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            S_ERR: begin
                state_nxt = S_ERR;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath bookkeeping: ready flag, move latch, ROM index, shadow state, counter, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r   <= 1'b0;
            auto_r    <= 1'b0;
            rom_idx_r <= 3'd0;
            move_r    <= MV_NONE;
            shadow_r  <= state_t'(4'b0000);
            moves_r   <= {CNT_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            ready_r <= (state_nxt == S_IDLE);
            if (state_nxt == S_ERR) begin
                err_r <= 1'b1;
            end
            if ((state_r == S_IDLE) && auto_start) begin
                auto_r    <= 1'b1;
                rom_idx_r <= 3'd0;
            end else if (accept_s) begin
                move_r <= move_e'(req_move);
            end
            if (state_r == S_ISSUE) begin
                shadow_r <= chk_next_s;
                if (moves_r != {CNT_W{1'b1}}) begin
                    moves_r <= moves_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            if ((state_r == S_VERIFY) && auto_r && (state_nxt == S_CHECK)) begin
                rom_idx_r <= rom_idx_r + 3'd1;
            end
        end
    end

    assign resp_code = resp_s;
    assign shadow    = shadow_r;
    assign moves     = moves_r;
    assign done      = (shadow_r == GOAL);
    assign err       = err_r;

endmodule

// File: tb/tb_wsc_sequencer.sv
// Self-checking bench for wsc_sequencer: directed vector table, hand-written corner sequences,
// and random manual moves scored against a bank-based puzzle model.
module tb_wsc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       auto_start = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_move = 2'd0;
    logic       req_ready, resp_valid, dp_step, dp_wolf, dp_sheep, dp_cab, done, err;
    logic [1:0] resp_code;
    logic [3:0] dp_state, shadow, moves;
    logic       dp_fault = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Model: bank of farmer, wolf, sheep, cabbage (0 near, 1 far).
    logic side [0:3];
    int   model_moves;

    typedef struct {
        logic [1:0] mv;
        logic [1:0] exp_code;
        logic [3:0] exp_shadow;
        logic [3:0] exp_moves;
    } vec_t;

    vec_t tbl [16];

    wsc_sequencer #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .auto_start(auto_start),
        .req_valid(req_valid), .req_move(req_move), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_code(resp_code),
        .dp_step(dp_step), .dp_wolf(dp_wolf), .dp_sheep(dp_sheep), .dp_cab(dp_cab),
        .dp_state(dp_state), .shadow(shadow), .moves(moves), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: performs the crossing on the dp_step edge unless a fault is injected.
    always @(posedge clk) begin
        if (rst) dp_state <= 4'b0000;
        else if (dp_step && !dp_fault) dp_state <= dp_state ^ {1'b1, dp_wolf, dp_sheep, dp_cab};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] onehot(input logic [1:0] mv);
        case (mv)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] pack_side();
        return {side[0], side[1], side[2], side[3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) side[i] = 1'b0;
        model_moves = 0;
    endtask

    // Moves the farmer (and passenger) if the passenger stands beside him and nothing gets eaten.
    task automatic model_eval(input logic [1:0] mv, output logic [1:0] code, output logic [3:0] nxt);
        logic b [0:3];
        logic u;
        int   p;
        p = (mv == 2'd0) ? 0 : 4 - int'(mv);
        b = side;
        if (p != 0 && side[p] != side[0]) begin
            code = 2'd1;
        end else begin
            b[0] = ~b[0];
            if (p != 0) b[p] = ~b[p];
            u = ~b[0];
            if ((b[1] == u && b[2] == u) || (b[2] == u && b[3] == u)) begin
                code = 2'd2;
            end else begin
                code = 2'd0;
                side = b;
                model_moves = (model_moves < 15) ? model_moves + 1 : 15;
            end
        end
        nxt = pack_side();
    endtask

    task automatic reset_dut();
        rst = 1'b1; req_valid = 1'b0; auto_start = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        tick();
        check("rst_ready", req_ready, 1);
        check("rst_shadow", shadow, 0);
        check("rst_moves", moves, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    // Manual request with cycle-exact checks of response, step and ready return.
    task automatic manual_move(input string tag, input logic [1:0] mv, input logic [1:0] exp_code,
                               input logic [3:0] exp_shadow, input logic [3:0] exp_moves);
        req_valid = 1'b1; req_move = mv;
        #1;
        check({tag, "_ready"}, req_ready, 1);
        tick();
        req_valid = 1'b0; req_move = 2'($urandom_range(0, 3));
        if (exp_code != 2'd0) begin
            check({tag, "_rv_chk"}, resp_valid, 1);
            check({tag, "_code"}, resp_code, exp_code);
            check({tag, "_nostep"}, dp_step, 0);
            tick();
            check({tag, "_ready_back"}, req_ready, 1);
        end else begin
            check({tag, "_rv_early"}, resp_valid, 0);
            tick();
            check({tag, "_step"}, dp_step, 1);
            check({tag, "_pass"}, {dp_wolf, dp_sheep, dp_cab}, onehot(mv));
            tick();
            check({tag, "_rv"}, resp_valid, 1);
            check({tag, "_code"}, resp_code, 0);
            tick();
            check({tag, "_ready_back"}, req_ready, (exp_shadow != 4'hF));
            check({tag, "_done"}, done, (exp_shadow == 4'hF));
        end
        check({tag, "_shadow"}, shadow, exp_shadow);
        check({tag, "_moves"}, moves, exp_moves);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int sol [7] = '{2, 0, 3, 2, 1, 0, 2};
        int k;
        logic [1:0] mv, code;
        logic [3:0] nxt;

        tbl[0]  = '{2'd3, 2'd2, 4'b0000, 4'd0};
        tbl[1]  = '{2'd1, 2'd2, 4'b0000, 4'd0};
        tbl[2]  = '{2'd0, 2'd2, 4'b0000, 4'd0};
        tbl[3]  = '{2'd2, 2'd0, 4'b1010, 4'd1};
        tbl[4]  = '{2'd1, 2'd1, 4'b1010, 4'd1};
        tbl[5]  = '{2'd3, 2'd1, 4'b1010, 4'd1};
        tbl[6]  = '{2'd2, 2'd0, 4'b0000, 4'd2};
        tbl[7]  = '{2'd2, 2'd0, 4'b1010, 4'd3};
        tbl[8]  = '{2'd0, 2'd0, 4'b0010, 4'd4};
        tbl[9]  = '{2'd3, 2'd0, 4'b1110, 4'd5};
        tbl[10] = '{2'd3, 2'd0, 4'b0010, 4'd6};
        tbl[11] = '{2'd1, 2'd0, 4'b1011, 4'd7};
        tbl[12] = '{2'd2, 2'd0, 4'b0001, 4'd8};
        tbl[13] = '{2'd3, 2'd0, 4'b1101, 4'd9};
        tbl[14] = '{2'd0, 2'd0, 4'b0101, 4'd10};
        tbl[15] = '{2'd2, 2'd0, 4'b1111, 4'd11};

        // Reset values, then ready one cycle after release.
        tick(); tick();
        check("reset_ready", req_ready, 0);
        check("reset_rv", resp_valid, 0);
        check("reset_step", dp_step, 0);
        check("reset_pass", {dp_wolf, dp_sheep, dp_cab}, 0);
        check("reset_shadow", shadow, 0);
        check("reset_moves", moves, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        rst = 1'b0;
        tick();
        check("reset_ready_after", req_ready, 1);

        for (int i = 0; i < 16; i++) begin
            manual_move($sformatf("tbl%0d", i), tbl[i].mv, tbl[i].exp_code, tbl[i].exp_shadow, tbl[i].exp_moves);
        end
        tick();
        check("done_absorb_ready", req_ready, 0);
        check("done_absorb_done", done, 1);

        // Auto replay with a simultaneous manual request that must lose.
        reset_dut();
        auto_start = 1'b1; req_valid = 1'b1; req_move = 2'd3;
        #1;
        check("auto_tie_ready", req_ready, 0);
        tick();
        auto_start = 1'b0; req_valid = 1'b0;
        k = 0;
        for (int c = 1; c <= 24; c++) begin
            check($sformatf("auto_step_c%0d", c), dp_step, (c % 3 == 2) && (c <= 20));
            if ((c % 3 == 2) && (c <= 20) && k < 7) begin
                check($sformatf("auto_pass%0d", k), {dp_wolf, dp_sheep, dp_cab}, onehot(2'(sol[k])));
                k++;
            end
            check($sformatf("auto_rv_c%0d", c), resp_valid, (c % 3 == 0) && (c <= 21));
            if ((c % 3 == 0) && (c <= 21)) check($sformatf("auto_code_c%0d", c), resp_code, 0);
            check($sformatf("auto_done_c%0d", c), done, (c >= 21));
            tick();
        end
        check("auto_shadow", shadow, 4'hF);
        check("auto_moves", moves, 7);
        check("auto_ready", req_ready, 0);
        check("auto_err", err, 0);

        // Datapath reports a stale state after the first step.
        reset_dut();
        dp_fault = 1'b1;
        req_valid = 1'b1; req_move = 2'd2;
        tick();
        req_valid = 1'b0;
        check("mm_rv_early", resp_valid, 0);
        tick();
        check("mm_step", dp_step, 1);
        tick();
        check("mm_rv", resp_valid, 1);
        check("mm_code", resp_code, 3);
        tick();
        check("mm_err", err, 1);
        check("mm_ready", req_ready, 0);
        req_valid = 1'b1; req_move = 2'd0;
        tick(); tick(); tick();
        check("mm_err_sticky", err, 1);
        check("mm_ready_stuck", req_ready, 0);
        check("mm_no_step", dp_step, 0);
        check("mm_no_rv", resp_valid, 0);
        req_valid = 1'b0;
        dp_fault = 1'b0;
        reset_dut();

        // Reset in the cycle after an accept aborts the move.
        req_valid = 1'b1; req_move = 2'd2;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ab_step", dp_step, 0);
        check("ab_rv", resp_valid, 0);
        check("ab_ready", req_ready, 0);
        check("ab_shadow", shadow, 0);
        check("ab_moves", moves, 0);
        check("ab_done_err", {done, err}, 0);
        tick();
        check("ab_ready_after", req_ready, 1);
        check("ab_step_after", dp_step, 0);
        model_reset();

        // Random manual moves against the bank model.
        for (int i = 0; i < 80; i++) begin
            mv = 2'($urandom_range(0, 3));
            model_eval(mv, code, nxt);
            manual_move($sformatf("rnd%0d", i), mv, code, nxt, 4'(model_moves));
            if (nxt == 4'hF) reset_dut();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wsc_sequencer.md
# wsc_sequencer

Move sequencer and legality gate in front of the wolf/sheep/cabbage crossing datapath. Accepts crossing requests over a valid/ready handshake (or replays the built-in 7-move solution in auto mode), checks each move against a shadow copy of the puzzle state, and issues only safe moves to the datapath as a one-cycle step. After every issued move it compares the datapath's reported state with the shadow copy, and flags completion when the goal state `4'b1111` is reached.

## Interface
- `CNT_W`, default 4: move-counter width; the counter saturates.
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `auto_start  in  1`: pulse in IDLE; starts ROM replay of the solution.
- `req_valid  in  1`: manual move request valid.
- `req_move  in  2`: move code: 0 boat alone, 1 cab, 2 sheep, 3 wolf.
- `req_ready  out  1`: high only in IDLE, and not while auto mode is active.
- `resp_valid  out  1`: one-cycle response strobe.
- `resp_code  out  2`: 0 OK, 1 passenger on far side, 2 unsafe result, 3 datapath mismatch.
- `dp_step  out  1`: one-cycle strobe; the datapath performs one crossing.
- `dp_wolf`, `dp_sheep`, `dp_cab`  out  1 each: at most one high, and only while `dp_step` is high.
- `dp_state  in  4`: datapath `{t,w,s,c}`.
- `shadow  out  4`: internal `{t,w,s,c}`.
- `moves  out  CNT_W`: issued-move count.
- `done  out  1`: `shadow == 4'b1111`.
- `err  out  1`: sticky mismatch flag.

## Operation
- FSM states: IDLE, CHECK, ISSUE, VERIFY, DONE, ERR.
- IDLE:
  - A request is accepted on `req_valid & req_ready`; `req_move` is latched.
  - `auto_start` loads ROM index 0, sets the auto flag and enters CHECK with ROM move 0.
- ROM sequence: sheep, none, wolf, sheep, cab, none, sheep.
- CHECK:
  - Legal when the passenger bit equals `t`. Move 0 is always passenger-legal.
  - Compute `next` with `t` and the passenger toggled.
  - `next` is unsafe if `(w==s && t!=s)` or `(s==c && t!=s)`.
  - On an illegal move: `resp_code` is 1 or 2, then return to IDLE. In auto mode an illegal move goes to ERR instead (not reachable with the correct ROM).
- ISSUE: assert `dp_step` and the one-hot passenger bit; `shadow <= next`; `moves` increments, saturating at all-ones.
- VERIFY:
  - If `dp_state == shadow`: `resp_code` 0. Then DONE if goal; else IDLE (manual) or CHECK with the next ROM index (auto).
  - If `dp_state != shadow`: `resp_code` 3, `err` set, go to ERR.
- `resp_valid` pulses once per move, in CHECK (illegal) or VERIFY, for manual and auto moves alike.
- DONE: absorbing; `req_ready` 0. Only `rst` exits.
- ERR: absorbing; `err` 1. Only `rst` exits.
- Simultaneous `auto_start` and `req_valid` in IDLE: auto wins and the request is not accepted (`req_ready` drops in the same cycle because it is gated by `auto_start`).
- `req_move` changes while not ready are ignored.

## Timing
- Reset values: all outputs 0, `shadow` 0, FSM in IDLE. `req_ready` becomes 1 in the first cycle after reset.
- Manual legal move, accepted at edge N:
  - CHECK in cycle N+1.
  - `dp_step` in cycle N+2.
  - VERIFY in cycle N+3, with `resp_valid` in N+3.
  - `req_ready` high again in N+4.
- Manual illegal move: `resp_valid` in N+1; `req_ready` high in N+2.
- Auto mode: 3 cycles per move. All 7 moves complete and `done` rises 21 cycles after the `auto_start` edge.
- `dp_state` is sampled in VERIFY, i.e. one cycle after `dp_step`. The datapath must update on the `dp_step` edge.
- `rst` mid-operation aborts at the next edge: no further `dp_step`, no pending `resp_valid`, counters and `shadow` cleared. The datapath is reset by the same `rst`.

## Structure
- `wsc_pkg` holds:
  - `move_e` enum (NONE, CAB, SHEEP, WOLF) and `resp_e` enum.
  - `state_t` as a 4-bit packed struct `{t,w,s,c}`.
  - `GOAL = 4'b1111`.
  - The 7-entry solution ROM constant.
  - `is_safe(state_t)` function.
- Sub-module `wsc_legal_chk`: combinational. Inputs: `shadow`, `move`. Outputs: `next`, `code`. Reused by the formal harness.
- The FSM, ROM index, counter and response logic live in `wsc_sequencer`.

## Test plan
- Reset, then `auto_start`: 7 `dp_step` pulses with passengers S,–,W,S,C,–,S; `shadow` reaches `4'b1111`; `moves == 7`; `done` in cycle 21; 7 OK responses.
- From reset, manual `req_move` 3 (wolf): `resp_code` 2 (sheep+cab left alone) in N+1; no `dp_step`; `shadow` stays `0000`.
- Manual sheep (2), then sheep again: first OK, `shadow` = `1010`; second `resp_code` 0 and `shadow` back to `0000`.
- From `shadow` `1010`, request cab (1): `resp_code` 1 (passenger on far side), because the cab bit 0 is not equal to `t` = 1.
- Datapath model forced to report `dp_state` `0000` after the first step: `resp_code` 3, `err` 1, FSM in ERR; `req_ready` stays 0 until `rst`.
- Assert `rst` in the cycle after a manual accept: no `dp_step`; all outputs 0 next cycle; `req_ready` 1 the cycle after.
